// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM state encoding,
// read-data source select, MMIO register offsets and default geometry.
package dmem_responder_pkg;

    localparam int          DEFAULT_ADDR_WIDTH = 12;
    localparam int          DEFAULT_DATA_WIDTH = 32;
    localparam logic [31:0] DEFAULT_MMIO_BASE  = 32'h0000_F000;

    localparam int MMIO_OFS_CYCLES = 0;
    localparam int MMIO_OFS_STORES = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dmem_state_e;

    // Source of q_dmem for the access sampled on the previous edge.
    typedef enum logic [1:0] {
        RD_ZERO,
        RD_RAM,
        RD_MMIO
    } rd_sel_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Processor <-> data-memory port: request fields driven by the pipeline (master),
// read data and status returned by the responder (slave).
interface dmem_responder_if
    import dmem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic [31:0]           address_dmem;
    logic [DATA_WIDTH-1:0] data;
    logic                  wren;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] q_dmem;
    logic                  busy;
    logic                  err_oob;

    modport master (
        output address_dmem, data, wren, err_clr,
        input  q_dmem, busy, err_oob
    );

    modport slave (
        input  address_dmem, data, wren, err_clr,
        output q_dmem, busy, err_oob
    );

endinterface

// File: rtl/dmem_ram_array.sv
// Single-port synchronous RAM, one-cycle read latency, write-first on a
// same-cycle read and write of one address.
module dmem_ram_array #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset term so it maps onto block RAM; the
    // responder's clear sweep is what gives it defined contents after reset.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: post-reset zero-fill sweep, range-checked RAM access
// with sticky error flag. Define DMEM_MMIO_EN to add cycle/store counters.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int          DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic [31:0] MMIO_BASE  = DEFAULT_MMIO_BASE
) (
    input  logic           clock,
    input  logic           reset,
    dmem_responder_if.slave bus
);

`ifdef DMEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    dmem_state_e           state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic                  ready, in_ram, mmio_hit, oob, ram_store;
    logic [31:0]           mmio_ofs;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata, q;
    rd_sel_e               rd_sel;
    logic                  err_oob;

    // Sweep state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && clr_ptr == '1) state_nxt = ST_READY;
    end

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and infers a latch.
    always_comb begin
        ram_we    = 1'b1;
        ram_addr  = clr_ptr;
        ram_wdata = '0;
        if (state == ST_READY) begin
            ram_we    = ram_store;
            ram_addr  = bus.address_dmem[ADDR_WIDTH-1:0];
            ram_wdata = bus.data;
        end
    end

    // Any set bit above the RAM index is out of RAM; no aliasing.
    assign ready     = (state == ST_READY);
    assign in_ram    = (bus.address_dmem[31:ADDR_WIDTH] == '0);
    assign mmio_ofs  = bus.address_dmem - MMIO_BASE;
    assign mmio_hit  = MMIO_EN && (mmio_ofs <= 32'(MMIO_OFS_STORES));
    assign oob       = ready && !in_ram && !mmio_hit;
    assign ram_store = ready && bus.wren && in_ram;

    dmem_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Error flag: a new OOB access outranks a coincident clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_oob <= 1'b0;
            rd_sel  <= RD_ZERO;
        end else begin
            if (oob)              err_oob <= 1'b1;
            else if (bus.err_clr) err_oob <= 1'b0;

            if (!ready || oob) rd_sel <= RD_ZERO;
            else if (in_ram)   rd_sel <= RD_RAM;
            else               rd_sel <= RD_MMIO;
        end
    end

`ifdef DMEM_MMIO_EN
    logic [31:0]           cycle_cnt, store_cnt;
    logic [DATA_WIDTH-1:0] mmio_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            store_cnt <= '0;
            mmio_q    <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (ram_store) store_cnt <= store_cnt + 32'd1;
            mmio_q <= (mmio_ofs == 32'(MMIO_OFS_CYCLES)) ? DATA_WIDTH'(cycle_cnt)
                                                         : DATA_WIDTH'(store_cnt);
        end
    end
`endif

    always_comb begin
        q = '0;
        case (rd_sel)
            RD_RAM:  q = ram_rdata;
`ifdef DMEM_MMIO_EN
            RD_MMIO: q = mmio_q;
`endif
            default: q = '0;
        endcase
    end

    assign bus.q_dmem  = q;
    assign bus.busy    = (state == ST_CLEAR);
    assign bus.err_oob = err_oob;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: clear sweep, reset restart, RAM access table,
// OOB flag behaviour and the DMEM_MMIO_EN counters (or their absence).
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int          AW        = 12;
    localparam int          DW        = 32;
    localparam int          DEPTH     = 1 << AW;
    localparam logic [31:0] MMIO_BASE = 32'h0000_F000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dmem_responder_if #(.DATA_WIDTH(DW)) bus ();

    dmem_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MMIO_BASE  (MMIO_BASE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        wren;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err_clr;
        logic [31:0] exp_q;
        logic        exp_err;
    } vec_t;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic c);
        bus.wren         = w;
        bus.address_dmem = a;
        bus.data         = d;
        bus.err_clr      = c;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < DEPTH + 16) begin
            cycle();
            n++;
        end
    endtask

    vec_t vecs[14];
    int   n;
    logic [31:0] c1, c2;

    initial begin
        vecs[0]  = '{1'b1, 32'd5,         32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b0, 32'd5,         32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'd9,         32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0};
        vecs[3]  = '{1'b0, 32'd9,         32'h0,        1'b0, 32'hA5A5A5A5, 1'b0};
        vecs[4]  = '{1'b0, 32'd0,         32'h0,        1'b0, 32'h0,        1'b0};
        vecs[5]  = '{1'b1, 32'd4096,      32'h1234,     1'b0, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 32'd0,         32'h0,        1'b0, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'h0001_0000, 32'h0,        1'b1, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 32'd5,         32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        vecs[9]  = '{1'b0, 32'h8000_0005, 32'h0,        1'b0, 32'h0,        1'b1};
        vecs[10] = '{1'b1, 32'h0000_1005, 32'h77,       1'b1, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 32'd5,         32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        vecs[12] = '{1'b1, 32'd4095,      32'h0BADF00D, 1'b0, 32'h0BADF00D, 1'b0};
        vecs[13] = '{1'b0, 32'd4095,      32'h0,        1'b0, 32'h0BADF00D, 1'b0};

        // Reset state
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) cycle();
        check("rst busy", bus.busy, 1'b1);
        check("rst q", bus.q_dmem, 32'h0);
        check("rst err", bus.err_oob, 1'b0);

        // Reset asserted 100 cycles into the sweep restarts it
        reset = 1'b1;
        repeat (100) cycle();
        check("busy mid sweep", bus.busy, 1'b1);
        reset = 1'b0;
        #1;
        check("busy after re-reset", bus.busy, 1'b1);
        check("q after re-reset", bus.q_dmem, 32'h0);
        cycle();
        reset = 1'b1;

        // Stores and OOB addresses during the sweep are ignored
        drive(1'b1, 32'd3, 32'hFFFF, 1'b0);
        repeat (2000) cycle();
        check("clear q", bus.q_dmem, 32'h0);
        check("clear err", bus.err_oob, 1'b0);
        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF, 1'b0);
        wait_ready(n);
        check("sweep length after restart", 32'(n + 2000), 32'(DEPTH));
        check("clear oob err", bus.err_oob, 1'b0);
        drive(1'b0, 32'd3, 32'd0, 1'b0);
        cycle();
        check("addr3 after clear", bus.q_dmem, 32'h0);
        check("addr3 err", bus.err_oob, 1'b0);

`ifdef DMEM_MMIO_EN
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(10 + i), 32'(i + 1), 1'b0);
            cycle();
        end
        drive(1'b0, MMIO_BASE + 32'd1, 32'd0, 1'b0);
        cycle();
        check("mmio stores", bus.q_dmem, 32'd3);
        check("mmio stores err", bus.err_oob, 1'b0);
        drive(1'b0, MMIO_BASE, 32'd0, 1'b0);
        cycle();
        c1 = bus.q_dmem;
        repeat (7) cycle();
        c2 = bus.q_dmem;
        check("mmio cycle delta", c2 - c1, 32'd7);
        drive(1'b1, MMIO_BASE, 32'h55, 1'b0);
        cycle();
        check("mmio write err", bus.err_oob, 1'b0);
        drive(1'b0, MMIO_BASE + 32'd1, 32'd0, 1'b0);
        cycle();
        check("mmio stores unchanged", bus.q_dmem, 32'd3);
        drive(1'b0, MMIO_BASE + 32'd2, 32'd0, 1'b0);
        cycle();
        check("mmio+2 q", bus.q_dmem, 32'h0);
        check("mmio+2 err", bus.err_oob, 1'b1);
`else
        drive(1'b0, MMIO_BASE, 32'd0, 1'b0);
        cycle();
        check("no-mmio q", bus.q_dmem, 32'h0);
        check("no-mmio err", bus.err_oob, 1'b1);
`endif
        drive(1'b0, 32'd0, 32'd0, 1'b1);
        cycle();
        check("err cleared", bus.err_oob, 1'b0);

        // Table of back-to-back READY accesses
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].wren, vecs[i].addr, vecs[i].data, vecs[i].err_clr);
            cycle();
            check($sformatf("vec%0d q", i), bus.q_dmem, vecs[i].exp_q);
            check($sformatf("vec%0d err", i), bus.err_oob, vecs[i].exp_err);
        end

        // Sweep zero-fills previously written words and lasts exactly DEPTH cycles
        drive(1'b1, 32'd0, 32'h1111_1111, 1'b0);
        cycle();
        drive(1'b1, 32'd7, 32'h7777_7777, 1'b0);
        cycle();
        drive(1'b0, 32'd7, 32'd0, 1'b0);
        cycle();
        check("prefill addr7", bus.q_dmem, 32'h7777_7777);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        wait_ready(n);
        check("sweep length", 32'(n), 32'(DEPTH));
        check("busy low", bus.busy, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        cycle();
        check("cleared addr0", bus.q_dmem, 32'h0);
        drive(1'b0, 32'd7, 32'd0, 1'b0);
        cycle();
        check("cleared addr7", bus.q_dmem, 32'h0);
        drive(1'b0, 32'd4095, 32'd0, 1'b0);
        cycle();
        check("cleared addr DEPTH-1", bus.q_dmem, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
